ssc_mem_ctrl: RTL and testbench

Parametrised single-port data memory with a four-phase request/ready handshake and programmable wait states. It is the next-generation SSC memory. Width, depth and access latency are generic. Storage is synchronous only: no combinational read path and no file I/O in RTL. It sits between the SSC datapath/controller and the address/data buses, and drives the same readMem/writeMem/rdyMem protocol.

---
 rtl/ssc_mem_pkg.sv | 30 +++
 rtl/ssc_mem_array.sv | 37 +++
 rtl/ssc_mem_ctrl.sv | 136 +++++++++++++
 tb/tb_ssc_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssc_mem_pkg.sv
// Shared types and constants for the SSC data memory controller.
// Optional build macro used by ssc_mem_ctrl: SSC_MEM_TRISTATE_EN.
package ssc_mem_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_WAIT_CYC = 0;
    localparam int CNT_W        = 4;

    // Controller FSM states; IDLE must stay the all-zero encoding (reset value).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Operation latched at accept time.
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Address width needed to index DEPTH words (at least one bit).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ssc_mem_array.sv
// Synchronous single-port word storage with a registered read port.
// Contents are never cleared; only the read register is reset.
module ssc_mem_array
    import ssc_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = idx_w(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: storage is not part of the reset domain.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port: updates only on a read access, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ssc_mem_ctrl.sv
// SSC data memory controller: four-phase readMem/writeMem/rdyMem handshake,
// WAIT_CYC programmable wait states, range check against DEPTH.
// Build macro SSC_MEM_TRISTATE_EN: when defined, outBus is released ('z)
// except while presenting read data in DONE; otherwise outBus always drives
// the last read value.
// Handshake: a request is a level held until rdyMem is seen; rdyMem then
// stays high until the accepted request line drops, and falls one edge later.
module ssc_mem_ctrl
    import ssc_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              readMem,
    input  logic              writeMem,
    input  logic [ADDR_W-1:0] addrBus,
    input  logic [DATA_W-1:0] inBus,
    output logic              rdyMem,
    output logic [DATA_W-1:0] outBus,
    output logic              errMem,
    output logic [1:0]        state_dbg
);

    localparam int AW = idx_w(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYC);

    state_t             state;
    op_t                op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rdy_q;
    logic               err_q;
    logic               zero_q;
    logic               in_range;
    logic               req_held;
    logic               arr_we;
    logic               arr_re;
    logic [DATA_W-1:0]  arr_rdata;
    logic [DATA_W-1:0]  rd_value;

    // Range check and "is the accepted request still asserted" are taken from
    // the latched transaction, never from the live buses.
    assign in_range = (32'(addr_q) < 32'(DEPTH));
    assign req_held = (op_q == OP_WR) ? writeMem : readMem;

    // The storage is touched only in ACCESS and only for in-range addresses.
    assign arr_we = (state == ACCESS) && (op_q == OP_WR) && in_range;
    assign arr_re = (state == ACCESS) && (op_q == OP_RD) && in_range;

    ssc_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (arr_we),
        .re     (arr_re),
        .addr   (addr_q[AW-1:0]),
        .wdata  (data_q),
        .rdata  (arr_rdata)
    );

    // Handshake FSM with wait counter and registered rdyMem/errMem.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_RD;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (readMem || writeMem) begin
                        op_q   <= writeMem ? OP_WR : OP_RD;
                        addr_q <= addrBus;
                        data_q <= inBus;
                        cnt_q  <= WAIT_CNT;
                        state  <= (WAIT_CNT != '0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    // Dropping the request here aborts with no side effects.
                    if (!req_held) begin
                        state <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    rdy_q <= 1'b1;
                    err_q <= !in_range;
                    // An out-of-range read presents zero instead of stale data.
                    if (op_q == OP_RD) begin
                        zero_q <= !in_range;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (!req_held) begin
                        rdy_q <= 1'b0;
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rd_value  = zero_q ? '0 : arr_rdata;
    assign rdyMem    = rdy_q;
    assign errMem    = err_q;
    assign state_dbg = state;

`ifdef SSC_MEM_TRISTATE_EN
    assign outBus = (rdy_q && (op_q == OP_RD)) ? rd_value : {DATA_W{1'bz}};
`else
    assign outBus = rd_value;
`endif

endmodule

// File: tb/tb_ssc_mem_ctrl.sv
// Bench for ssc_mem_ctrl: three instances (WAIT_CYC 0/3/4, DEPTH 256/200/200)
// driven by directed and randomized transactions, checked every cycle against
// a transaction-level model (expected edge windows plus a word array).
module tb_ssc_mem_ctrl;
    import ssc_mem_pkg::*;

    localparam int NI    = 3;
    localparam int DW    = 16;
    localparam int AWD   = 8;
    localparam int NEVER = 32'h3fff_ffff;

    function automatic int wc_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- DUT signals ----------------
    logic           rd_req   [NI];
    logic           wr_req   [NI];
    logic [AWD-1:0] addr_bus [NI];
    logic [DW-1:0]  in_bus   [NI];
    logic           rdy      [NI];
    logic [DW-1:0]  out_bus  [NI];
    logic           err      [NI];
    logic [1:0]     st       [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int GW = (g == 0) ? 0 : ((g == 1) ? 3 : 4);
        localparam int GD = (g == 0) ? 256 : 200;
        ssc_mem_ctrl #(
            .DATA_W   (DW),
            .ADDR_W   (AWD),
            .DEPTH    (GD),
            .WAIT_CYC (GW)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .readMem   (rd_req[g]),
            .writeMem  (wr_req[g]),
            .addrBus   (addr_bus[g]),
            .inBus     (in_bus[g]),
            .rdyMem    (rdy[g]),
            .outBus    (out_bus[g]),
            .errMem    (err[g]),
            .state_dbg (st[g])
        );
    end

    // ---------------- model state ----------------
    bit             have_txn [NI];
    int             acc_e    [NI];
    int             drop_e   [NI];
    bit             op_wr    [NI];
    logic [AWD-1:0] t_addr   [NI];
    logic [DW-1:0]  t_data   [NI];
    bit             applied  [NI];
    logic [DW-1:0]  mem_m    [NI][256];
    bit             known    [NI][256];
    logic [DW-1:0]  last_rd  [NI];
    bit             last_known [NI];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            have_txn[k]   = 1'b0;
            last_rd[k]    = '0;
            last_known[k] = 1'b1;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) begin
            int n;
            int w;
            bit oor;
            bit aborted;
            bit exp_rdy;
            bit in_txn;
            n       = edge_n;
            w       = wc_of(k);
            oor     = int'(t_addr[k]) >= depth_of(k);
            aborted = have_txn[k] && (drop_e[k] <= acc_e[k] + w);
            // Effect of the access lands on edge acc+w+1.
            if (have_txn[k] && !aborted && !applied[k] && n >= acc_e[k] + w + 1) begin
                if (op_wr[k]) begin
                    if (!oor) begin
                        mem_m[k][t_addr[k]] = t_data[k];
                        known[k][t_addr[k]] = 1'b1;
                    end
                end else if (oor) begin
                    last_rd[k]    = '0;
                    last_known[k] = 1'b1;
                end else begin
                    last_rd[k]    = mem_m[k][t_addr[k]];
                    last_known[k] = known[k][t_addr[k]];
                end
                applied[k] = 1'b1;
            end
            exp_rdy = have_txn[k] && !aborted && (n >= acc_e[k] + w + 1) && (n < drop_e[k]);
            in_txn  = have_txn[k] && (n >= acc_e[k]) && (n < drop_e[k]);
            check("rdyMem", k, 32'(rdy[k]), 32'(exp_rdy));
            check("errMem", k, 32'(err[k]), 32'(exp_rdy && oor));
            if (last_known[k]) check("outBus", k, 32'(out_bus[k]), 32'(last_rd[k]));
            if (!in_txn) check("fsm_idle", k, 32'(st[k]), 32'(IDLE));
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge right after the drop edge.
    task automatic txn(input int k, input bit rd, input bit wr,
                       input logic [AWD-1:0] a, input logic [DW-1:0] d,
                       input bit abort, input int hold,
                       output int lat, output logic e_at);
        int w;
        int steps;
        int first;
        w     = wc_of(k);
        first = -1;
        e_at  = 1'b0;
        rd_req[k] = rd;  wr_req[k] = wr;  addr_bus[k] = a;  in_bus[k] = d;
        t_addr[k] = a;   t_data[k] = d;   op_wr[k] = wr;    applied[k] = 1'b0;
        acc_e[k]  = edge_n + 1;  drop_e[k] = NEVER;  have_txn[k] = 1'b1;
        @(negedge clk);
        steps = (abort && w > 0) ? (hold % w) : (w + 1 + hold);
        for (int i = 0; i <= steps; i++) begin
            if (rdy[k] && first < 0) begin
                first = i;
                e_at  = err[k];
            end
            if (i < steps) begin
                addr_bus[k] = AWD'($urandom);
                in_bus[k]   = DW'($urandom);
                @(negedge clk);
            end
        end
        rd_req[k] = 1'b0;
        wr_req[k] = 1'b0;
        drop_e[k] = edge_n + 1;
        @(negedge clk);
        lat = (first < 0) ? 0 : first + 1;
    endtask

    task automatic run_random(input int k);
        for (int t = 0; t < 40; t++) begin
            int r;
            int lat;
            logic e;
            bit rd;
            bit wr;
            bit ab;
            logic [AWD-1:0] a;
            r  = $urandom_range(0, 9);
            rd = (r <= 4) || (r == 9);
            wr = (r >= 5);
            if (k != 0 && $urandom_range(0, 3) == 0) a = AWD'($urandom_range(195, 230));
            else a = AWD'($urandom_range(0, 15));
            ab = (wc_of(k) > 0) && ($urandom_range(0, 4) == 0);
            txn(k, rd, wr, a, DW'($urandom), ab, $urandom_range(0, 3), lat, e);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got no completion, required finish before 500000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        logic e;
        for (int k = 0; k < NI; k++) begin
            rd_req[k] = 1'b0;  wr_req[k] = 1'b0;
            addr_bus[k] = '0;  in_bus[k] = '0;
            for (int a = 0; a < 256; a++) known[k][a] = 1'b0;
        end
        model_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("reset_rdy", k, 32'(rdy[k]), 32'h0);
            check("reset_out", k, 32'(out_bus[k]), 32'h0);
            check("reset_err", k, 32'(err[k]), 32'h0);
            check("reset_state", k, 32'(st[k]), 32'(IDLE));
        end

        // Basic write then read, no wait states.
        txn(0, 1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1, lat, e);
        check("basic_wr_latency", 0, 32'(lat), 32'd2);
        txn(0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 2, lat, e);
        check("basic_rd_latency", 0, 32'(lat), 32'd2);
        check("basic_rd_data", 0, 32'(out_bus[0]), 32'hBEEF);
        check("basic_rd_err", 0, 32'(e), 32'h0);

        // Simultaneous request: write wins.
        txn(0, 1'b1, 1'b1, 8'h05, 16'h1234, 1'b0, 0, lat, e);
        txn(0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 0, lat, e);
        check("simul_rd_data", 0, 32'(out_bus[0]), 32'h1234);

        // Wait states (3) and a held request.
        txn(1, 1'b0, 1'b1, 8'h00, 16'hA5A5, 1'b0, 0, lat, e);
        txn(1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 3, lat, e);
        check("wait3_latency", 1, 32'(lat), 32'd5);
        check("wait3_rd_data", 1, 32'(out_bus[1]), 32'hA5A5);

        // Out of range on DEPTH=200.
        txn(1, 1'b0, 1'b1, 8'd220, 16'hFFFF, 1'b0, 1, lat, e);
        check("oor_wr_latency", 1, 32'(lat), 32'd5);
        check("oor_wr_err", 1, 32'(e), 32'h1);
        txn(1, 1'b1, 1'b0, 8'd220, 16'h0000, 1'b0, 0, lat, e);
        check("oor_rd_err", 1, 32'(e), 32'h1);
        check("oor_rd_data", 1, 32'(out_bus[1]), 32'h0);
        txn(1, 1'b1, 1'b0, 8'd0, 16'h0000, 1'b0, 0, lat, e);
        check("oor_addr0_err", 1, 32'(e), 32'h0);
        check("oor_addr0_data", 1, 32'(out_bus[1]), 32'hA5A5);

        // Abort in WAIT (4 wait states).
        txn(2, 1'b0, 1'b1, 8'h33, 16'h5555, 1'b0, 0, lat, e);
        txn(2, 1'b0, 1'b1, 8'h33, 16'h0BAD, 1'b1, 2, lat, e);
        check("abort_no_rdy", 2, 32'(lat), 32'd0);
        txn(2, 1'b1, 1'b0, 8'h33, 16'h0000, 1'b0, 0, lat, e);
        check("abort_rd_data", 2, 32'(out_bus[2]), 32'h5555);

        // Reset pulsed while a read sits in WAIT.
        rd_req[2] = 1'b1;  addr_bus[2] = 8'h33;
        t_addr[2] = 8'h33; op_wr[2] = 1'b0; applied[2] = 1'b0;
        acc_e[2] = edge_n + 1;  drop_e[2] = NEVER;  have_txn[2] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_req[2] = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_state", 2, 32'(st[2]), 32'(IDLE));
        check("rst_mid_rdy", 2, 32'(rdy[2]), 32'h0);
        check("rst_mid_out", 2, 32'(out_bus[2]), 32'h0);
        txn(2, 1'b1, 1'b0, 8'h33, 16'h0000, 1'b0, 0, lat, e);
        check("rst_mem_kept", 2, 32'(out_bus[2]), 32'h5555);
        txn(0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 0, lat, e);
        check("rst_mem_kept", 0, 32'(out_bus[0]), 32'hBEEF);

        // Randomized traffic on all instances in parallel.
        fork
            run_random(0);
            run_random(1);
            run_random(2);
        join

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
